// File: rtl/moesi_bus_controller.sv
// Shared-bus side of a MOESI protocol: round-robin arbitration, command broadcast,
// snoop collection and data-source selection (owning cache or memory).
module moesi_bus_controller #(
  parameter int unsigned N_CACHES = 3,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_CACHES-1:0]          req_valid,
  input  logic [N_CACHES-1:0]          req_read,
  input  logic [N_CACHES-1:0]          req_rwitm,
  input  logic [N_CACHES-1:0]          req_invalidate,
  input  logic [N_CACHES*ADDR_W-1:0]   req_address,
  input  logic [N_CACHES-1:0]          snoop_shared,
  input  logic [N_CACHES-1:0]          snoop_abort,
  input  logic [3*N_CACHES-1:0]        snoop_state,
  input  logic                         mem_ready,
  output logic [N_CACHES-1:0]          grant,
  output logic                         bus_read,
  output logic                         bus_rwitm,
  output logic                         bus_invalidate,
  output logic [ADDR_W-1:0]            bus_address,
  output logic [2:0]                   bus_from_state,
  output logic                         bus_shared,
  output logic                         mem_read,
  output logic [N_CACHES-1:0]          done
);

  localparam int unsigned IDX_W = (N_CACHES > 1) ? $clog2(N_CACHES) : 1;

  localparam logic [2:0] ST_M     = 3'b001;
  localparam logic [2:0] ST_O     = 3'b011;
  localparam logic [2:0] ST_E     = 3'b100;
  localparam logic [2:0] SRC_NONE = 3'b000;
  localparam logic [2:0] SRC_MEM  = 3'b101;

  typedef enum logic [2:0] {IDLE, BCAST, XFER, MEM, DONE} state_t;

  state_t              state;
  logic [IDX_W-1:0]    last_grant;
  logic [IDX_W-1:0]    cur_idx;

  logic [N_CACHES-1:0] eligible;
  logic [N_CACHES-1:0] snoop_mask;
  logic                arb_found;
  logic [IDX_W-1:0]    arb_idx;
  logic [ADDR_W-1:0]   arb_addr;
  logic                arb_read;
  logic                arb_rwitm;
  logic                arb_inval;
  logic                sup_found;
  logic [2:0]          sup_state;
  logic                shared_any;

  assign eligible = req_valid & (req_read | req_rwitm | req_invalidate);

  // Round-robin search upward from the cache after the previous owner.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int unsigned k = 1; k <= N_CACHES; k++) begin
      if (!arb_found && eligible[IDX_W'((32'(last_grant) + k) % N_CACHES)]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'((32'(last_grant) + k) % N_CACHES);
      end
    end
  end

  assign arb_addr  = req_address[32'(arb_idx)*ADDR_W +: ADDR_W];
  assign arb_read  = req_read[arb_idx];
  assign arb_rwitm = req_rwitm[arb_idx];
  assign arb_inval = req_invalidate[arb_idx];

  // Snoop replies from everyone but the requester; supplier is the lowest
  // aborting cache that actually holds a dirty or exclusive copy.
  assign snoop_mask = ~grant;
  assign shared_any = |(snoop_shared & snoop_mask);

  always_comb begin
    sup_found = 1'b0;
    sup_state = SRC_MEM;
    for (int unsigned i = 0; i < N_CACHES; i++) begin
      if (!sup_found && snoop_abort[i] && snoop_mask[i] &&
          (snoop_state[3*i +: 3] inside {ST_M, ST_O, ST_E})) begin
        sup_found = 1'b1;
        sup_state = snoop_state[3*i +: 3];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= IDX_W'(N_CACHES - 1);
      cur_idx        <= '0;
      grant          <= '0;
      bus_read       <= 1'b0;
      bus_rwitm      <= 1'b0;
      bus_invalidate <= 1'b0;
      bus_address    <= '0;
      bus_from_state <= SRC_NONE;
      bus_shared     <= 1'b0;
      mem_read       <= 1'b0;
      done           <= '0;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          if (arb_found) begin
            state          <= BCAST;
            cur_idx        <= arb_idx;
            grant          <= N_CACHES'(1) << arb_idx;
            bus_address    <= arb_addr;
            bus_rwitm      <= arb_rwitm;
            bus_invalidate <= !arb_rwitm && arb_inval;
            bus_read       <= !arb_rwitm && !arb_inval && arb_read;
          end
        end
        BCAST: begin
          bus_read       <= 1'b0;
          bus_rwitm      <= 1'b0;
          bus_invalidate <= 1'b0;
          bus_shared     <= shared_any;
          if (bus_invalidate) begin
            state          <= DONE;
            bus_from_state <= SRC_NONE;
            done           <= grant;
          end else if (sup_found) begin
            state          <= XFER;
            bus_from_state <= sup_state;
          end else begin
            state          <= MEM;
            bus_from_state <= SRC_MEM;
            mem_read       <= 1'b1;
          end
        end
        XFER: begin
          state <= DONE;
          done  <= grant;
        end
        MEM: begin
          if (mem_ready) begin
            state    <= DONE;
            mem_read <= 1'b0;
            done     <= grant;
          end
        end
        DONE: begin
          state          <= IDLE;
          last_grant     <= cur_idx;
          grant          <= '0;
          bus_address    <= '0;
          bus_from_state <= SRC_NONE;
          bus_shared     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_moesi_bus_controller.sv
// Self-checking bench for moesi_bus_controller: directed scenarios plus random
// transactions compared against a transaction-level reference model.
module tb_moesi_bus_controller;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_read, req_rwitm, req_invalidate;
  logic [N*AW-1:0] req_address;
  logic [N-1:0]    snoop_shared, snoop_abort;
  logic [3*N-1:0]  snoop_state;
  logic            mem_ready;
  logic [N-1:0]    grant, done;
  logic            bus_read, bus_rwitm, bus_invalidate;
  logic [AW-1:0]   bus_address;
  logic [2:0]      bus_from_state;
  logic            bus_shared, mem_read;

  int checks   = 0;
  int failures = 0;
  int model_last = N - 1;

  always #5 clock = ~clock;

  moesi_bus_controller #(.N_CACHES(N), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_read(req_read), .req_rwitm(req_rwitm),
    .req_invalidate(req_invalidate), .req_address(req_address),
    .snoop_shared(snoop_shared), .snoop_abort(snoop_abort), .snoop_state(snoop_state),
    .mem_ready(mem_ready), .grant(grant), .bus_read(bus_read), .bus_rwitm(bus_rwitm),
    .bus_invalidate(bus_invalidate), .bus_address(bus_address),
    .bus_from_state(bus_from_state), .bus_shared(bus_shared),
    .mem_read(mem_read), .done(done)
  );

  // Reference model: winner is the eligible cache with the fewest steps past the last owner.
  function automatic int model_winner();
    int best   = -1;
    int best_d = N + 1;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && (req_read[i] || req_rwitm[i] || req_invalidate[i])) begin
        int d;
        d = (i - model_last - 1 + 2 * N) % N;
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    return best;
  endfunction

  // 1 read, 2 invalidate, 3 rwitm
  function automatic int model_cmd(input int w);
    if (req_rwitm[w])      return 3;
    if (req_invalidate[w]) return 2;
    return 1;
  endfunction

  function automatic logic [2:0] model_src(input int w, input int cmd);
    logic [2:0] st;
    if (cmd == 2) return 3'b000;
    for (int i = 0; i < N; i++) begin
      st = snoop_state[3*i +: 3];
      if (i != w && snoop_abort[i] && (st == 3'b001 || st == 3'b011 || st == 3'b100))
        return st;
    end
    return 3'b101;
  endfunction

  function automatic logic model_shared(input int w);
    for (int i = 0; i < N; i++)
      if (i != w && snoop_shared[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_inputs();
    req_valid = '0; req_read = '0; req_rwitm = '0; req_invalidate = '0;
    req_address = '0; snoop_shared = '0; snoop_abort = '0; snoop_state = '0;
    mem_ready = 1'b0;
  endtask

  // One full transaction from the IDLE sampling edge through the following IDLE cycle.
  task automatic run_txn(input int mem_wait, input bit drop, input string tag,
                         output logic [N-1:0] obs_grant);
    int w, cmd;
    logic [2:0] src;
    logic shr;
    logic [AW-1:0] addr;
    logic [N-1:0] g;
    w = model_winner();
    obs_grant = 'x;
    if (w < 0) begin
      checks++; failures++;
      $display("FAIL %s setup: no eligible request", tag);
      return;
    end
    cmd  = model_cmd(w);
    src  = model_src(w, cmd);
    shr  = model_shared(w);
    addr = req_address[w*AW +: AW];
    g    = N'(1) << w;

    @(posedge clock); #1;
    obs_grant = grant;
    checks++;
    if (grant !== g || bus_address !== addr || bus_read !== (cmd == 1) ||
        bus_rwitm !== (cmd == 3) || bus_invalidate !== (cmd == 2) ||
        bus_from_state !== 3'b000 || mem_read !== 1'b0 || done !== '0) begin
      failures++;
      $display("FAIL %s bcast: grant=%b addr=%h r/rw/inv=%b%b%b src=%b mem=%b done=%b; want grant=%b addr=%h cmd=%0d src=000",
               tag, grant, bus_address, bus_read, bus_rwitm, bus_invalidate, bus_from_state,
               mem_read, done, g, addr, cmd);
    end

    @(posedge clock); #1;
    checks++;
    if (grant !== g || bus_address !== addr || {bus_read, bus_rwitm, bus_invalidate} !== 3'b000 ||
        bus_from_state !== src || bus_shared !== shr || mem_read !== (src == 3'b101) ||
        done !== ((cmd == 2) ? g : {N{1'b0}})) begin
      failures++;
      $display("FAIL %s source: grant=%b cmds=%b%b%b src=%b shared=%b mem=%b done=%b; want grant=%b src=%b shared=%b",
               tag, grant, bus_read, bus_rwitm, bus_invalidate, bus_from_state, bus_shared,
               mem_read, done, g, src, shr);
    end

    if (cmd != 2) begin
      if (src == 3'b101) begin
        for (int k = 0; k < mem_wait; k++) begin
          @(posedge clock); #1;
          checks++;
          if (mem_read !== 1'b1 || done !== '0 || grant !== g) begin
            failures++;
            $display("FAIL %s mem_wait: mem=%b done=%b grant=%b; want mem=1 done=0 grant=%b",
                     tag, mem_read, done, grant, g);
          end
        end
        mem_ready = 1'b1;
      end
      @(posedge clock); #1;
      mem_ready = 1'b0;
      checks++;
      if (done !== g || mem_read !== 1'b0 || grant !== g || bus_from_state !== src ||
          bus_shared !== shr) begin
        failures++;
        $display("FAIL %s done: done=%b mem=%b grant=%b src=%b shared=%b; want done=%b src=%b shared=%b",
                 tag, done, mem_read, grant, bus_from_state, bus_shared, g, src, shr);
      end
    end

    if (drop) req_valid = '0;
    model_last = w;

    @(posedge clock); #1;
    checks++;
    if (grant !== '0 || done !== '0 || bus_from_state !== 3'b000 || bus_shared !== 1'b0 ||
        mem_read !== 1'b0 || bus_address !== '0 || {bus_read, bus_rwitm, bus_invalidate} !== 3'b000) begin
      failures++;
      $display("FAIL %s idle: grant=%b done=%b src=%b shared=%b mem=%b addr=%h; want all zero",
               tag, grant, done, bus_from_state, bus_shared, mem_read, bus_address);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_last = N - 1;
    checks++;
    if ({grant, bus_read, bus_rwitm, bus_invalidate, bus_address, bus_from_state,
         bus_shared, mem_read, done} !== '0) begin
      failures++;
      $display("FAIL reset: grant=%b cmds=%b%b%b addr=%h src=%b shared=%b mem=%b done=%b; want all zero",
               grant, bus_read, bus_rwitm, bus_invalidate, bus_address, bus_from_state,
               bus_shared, mem_read, done);
    end
  endtask

  task automatic test_mem_read();
    logic [N-1:0] og;
    clear_inputs();
    req_valid = 3'b001; req_read = 3'b001;
    req_address[0*AW +: AW] = 8'h3A;
    run_txn(1, 1'b1, "mem_read", og);
  endtask

  task automatic test_intervention();
    logic [N-1:0] og;
    clear_inputs();
    req_valid = 3'b010; req_rwitm = 3'b010;
    req_address[1*AW +: AW] = 8'hC5;
    snoop_abort[2] = 1'b1; snoop_state[2*3 +: 3] = 3'b001;
    run_txn(0, 1'b1, "intervention", og);
  endtask

  task automatic test_shared_owner();
    logic [N-1:0] og;
    clear_inputs();
    req_valid = 3'b001; req_read = 3'b001;
    req_address[0*AW +: AW] = 8'h51;
    snoop_abort[1] = 1'b1; snoop_shared[1] = 1'b1; snoop_state[1*3 +: 3] = 3'b011;
    snoop_shared[2] = 1'b1; snoop_state[2*3 +: 3] = 3'b010;
    run_txn(0, 1'b1, "shared_owner", og);
  endtask

  task automatic test_invalidate();
    logic [N-1:0] og;
    clear_inputs();
    req_valid = 3'b100; req_invalidate = 3'b100;
    req_address[2*AW +: AW] = 8'h7E;
    snoop_shared[0] = 1'b1;
    run_txn(0, 1'b1, "invalidate", og);
  endtask

  task automatic test_round_robin();
    logic [N-1:0] og;
    logic [N-1:0] want [4];
    want[0] = 3'b001; want[1] = 3'b010; want[2] = 3'b100; want[3] = 3'b001;
    test_reset();
    req_valid = 3'b111; req_read = 3'b111;
    for (int i = 0; i < N; i++) req_address[i*AW +: AW] = AW'(8'h10 + i);
    for (int t = 0; t < 4; t++) begin
      run_txn(0, 1'b0, "round_robin", og);
      checks++;
      if (og !== want[t]) begin
        failures++;
        $display("FAIL rr_order[%0d]: grant=%b; want %b", t, og, want[t]);
      end
    end
    clear_inputs();
    @(posedge clock); #1;
  endtask

  task automatic test_no_command();
    logic [N-1:0] og;
    logic [N-1:0] want [4];
    want[0] = 3'b001; want[1] = 3'b100; want[2] = 3'b001; want[3] = 3'b100;
    test_reset();
    req_valid = 3'b010;
    repeat (3) begin
      @(posedge clock); #1;
      checks++;
      if (grant !== '0 || bus_read !== 1'b0) begin
        failures++;
        $display("FAIL no_cmd_idle: grant=%b bus_read=%b; want 0", grant, bus_read);
      end
    end
    req_valid = 3'b111; req_read = 3'b101;
    for (int t = 0; t < 4; t++) begin
      run_txn(0, 1'b0, "no_command", og);
      checks++;
      if (og !== want[t]) begin
        failures++;
        $display("FAIL no_cmd_order[%0d]: grant=%b; want %b", t, og, want[t]);
      end
    end
    clear_inputs();
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_mem();
    logic [N-1:0] og;
    clear_inputs();
    req_valid = 3'b010; req_read = 3'b010;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++;
    if (mem_read !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_mem setup: mem_read=%b; want 1", mem_read);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    req_valid = '0;
    model_last = N - 1;
    checks++;
    if ({grant, bus_read, bus_rwitm, bus_invalidate, bus_address, bus_from_state,
         bus_shared, mem_read, done} !== '0) begin
      failures++;
      $display("FAIL rst_mid_mem: grant=%b src=%b mem=%b done=%b; want all zero",
               grant, bus_from_state, mem_read, done);
    end
    @(posedge clock); #1;
    checks++;
    if (done !== '0 || grant !== '0) begin
      failures++;
      $display("FAIL rst_mid_mem late_done: done=%b grant=%b; want 0", done, grant);
    end
    req_valid = 3'b111; req_read = 3'b111;
    run_txn(0, 1'b1, "after_reset", og);
    checks++;
    if (og !== 3'b001) begin
      failures++;
      $display("FAIL rst_next_grant: grant=%b; want 001", og);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [N-1:0] og;
    for (int it = 0; it < 30; it++) begin
      clear_inputs();
      req_valid      = N'($urandom);
      req_read       = N'($urandom);
      req_rwitm      = N'($urandom);
      req_invalidate = N'($urandom);
      snoop_shared   = N'($urandom);
      snoop_abort    = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_address[i*AW +: AW] = AW'($urandom);
        snoop_state[3*i +: 3]   = 3'($urandom_range(0, 7));
      end
      if (model_winner() < 0) begin
        @(posedge clock); #1;
        checks++;
        if (grant !== '0 || {bus_read, bus_rwitm, bus_invalidate} !== 3'b000) begin
          failures++;
          $display("FAIL random_idle[%0d]: grant=%b; want 000", it, grant);
        end
      end else begin
        run_txn($urandom_range(0, 3), 1'b1, "random", og);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_mem_read();
    test_intervention();
    test_shared_owner();
    test_invalidate();
    test_round_robin();
    test_no_command();
    test_reset_mid_mem();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/moesi_bus_controller.md
# moesi_bus_controller

Shared-bus side of the MOESI coherency protocol: arbitrates among N cache controllers, broadcasts the winning read / rwitm / invalidate transaction to all snoopers, and collects their shared/intervention replies. Also selects the data source (owning cache or memory) and reports it back as `bus_from_state`. Sits between the per-cache MOESI controllers and main memory; it is the responder to the controllers' bus requests.

## Interface
Parameters:
- `N_CACHES`, 3: number of attached caches (2..8).
- `ADDR_W`, 8: line address width.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  N_CACHES  cache i requests the bus; held until `done[i]`.
- `req_read`, `req_rwitm`, `req_invalidate`  in  N_CACHES each  per-cache command bits.
- `req_address`  in  N_CACHES*ADDR_W  cache i address at bits [i*ADDR_W +: ADDR_W].
- `snoop_shared`  in  N_CACHES  snooper i holds the line (its `shared` reply).
- `snoop_abort`  in  N_CACHES  snooper i intervenes (its `abort_mem_access_next`).
- `snoop_state`  in  3*N_CACHES  current MOESI state of the line in snooper i (000 I, 001 M, 010 S, 011 O, 100 E).
- `mem_ready`  in  1  memory read complete.
- `grant`  out  N_CACHES  one-hot owner of the current transaction.
- `bus_read`, `bus_rwitm`, `bus_invalidate`  out  1 each  broadcast command.
- `bus_address`  out  ADDR_W  broadcast address.
- `bus_from_state`  out  3  data source: 001 FROM_M, 011 FROM_O, 100 FROM_E, 101 FROM_MEM, 000 none.
- `bus_shared`  out  1  OR of `snoop_shared` over non-requesting caches.
- `mem_read`  out  1  memory read request.
- `done`  out  N_CACHES  one-cycle completion pulse to the requester.

## Operation
- FSM states: IDLE, BCAST, XFER, MEM, DONE.
- IDLE: a cache is eligible if `req_valid[i]` is set and at least one command bit is set. Requests with no command bit are never granted.
  - Arbitration is round-robin, searching upward from `last_grant+1` with wrap-around.
  - The winner's address and command are latched. Command priority within one cache: rwitm > invalidate > read.
  - Go to BCAST. With no eligible request, stay in IDLE.
- BCAST (exactly 1 cycle): `grant`, `bus_address` and exactly one `bus_*` command are driven. Snoop inputs are sampled at the end of this cycle; the requester's own bits are masked.
  - invalidate: go to DONE; `bus_from_state` = 000.
  - read/rwitm with an aborting snooper: the supplier is the lowest-index aborting snooper whose state is M, O or E. `bus_from_state` = that state's code (M→001, O→011, E→100). Go to XFER.
  - Otherwise: `bus_from_state` = 101; go to MEM.
  - `bus_shared` is latched from the masked OR of `snoop_shared`.
  - An abort whose state is not M/O/E is ignored, and memory supplies the data.
- XFER: 1 cycle (cache-to-cache transfer), then DONE.
- MEM: `mem_read` is held high. On `mem_ready`, go to DONE.
- DONE: `done[grant]` pulses high for 1 cycle. `last_grant` is updated. Go to IDLE.
- `grant`, `bus_address`, `bus_from_state` and `bus_shared` are held from BCAST (source fields from the cycle after) through DONE. They return to 0 in IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, `last_grant` = N_CACHES-1 (so cache 0 wins first).
- Reset asserted in any state aborts the transaction next edge: no `done` pulse, `mem_read` dropped.
- Request sampled in IDLE at cycle 0: BCAST at cycle 1.
  - invalidate: DONE at cycle 2.
  - cache supply: XFER at 2, DONE at 3.
  - memory: MEM from cycle 2; `mem_ready` seen in cycle m gives DONE at m+1 (earliest 3).
- Minimum 1 IDLE cycle between transactions.
- All outputs are registered. Snoop inputs are used combinationally only at the BCAST sampling edge.
- Requests arriving during a transaction wait. A requester dropping `req_valid` mid-transaction does not cancel it.

## Test plan
- Memory read: reset, cache0 `req_read`, addr 0x3A, no snoop replies, `mem_ready` 2 cycles after `mem_read` rises. Expect `grant`=001, `bus_read`=1 at cycle 1, `mem_read` cycles 2-3, `bus_from_state`=101, `bus_shared`=0, `done[0]` at cycle 4.
- Intervention: cache1 `req_rwitm`, snooper2 `snoop_abort`=1, state 001. Expect `bus_rwitm`=1 at cycle 1, XFER at 2, `bus_from_state`=001, `mem_read` never high, `done[1]` at cycle 3.
- Shared read from owner: cache0 read, snooper1 state 011 with abort+shared, snooper2 state 010 with shared. Expect `bus_from_state`=011, `bus_shared`=1, supplier cache1.
- Invalidate: cache2 `req_invalidate`. Expect `bus_invalidate`=1 at cycle 1, `done[2]` at cycle 2, `bus_from_state`=000.
- Round-robin fairness: all three caches request reads continuously. Expect grant order 0,1,2,0. A cache with `req_valid`=1 but no command bit is never granted.
- Reset mid-MEM: assert `reset` while `mem_read`=1. Expect all outputs 0 next cycle, no `done` pulse, and the next grant goes to cache 0.
